// File: rtl/bayer_rgb_reader_pkg.sv
// Shared constants for the Bayer quad reader: colour-pattern codes and default widths.
package bayer_pkg;

  localparam int BAYER_GRBG = 0;
  localparam int BAYER_RGGB = 1;
  localparam int BAYER_BGGR = 2;
  localparam int BAYER_GBRG = 3;

  localparam int PIX_W_DEF  = 12;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/bayer_rgb_reader_if.sv
// Pixel-stream bus between the line buffer taps and the RGB reader, plus its RGB output side.
interface bayer_rgb_reader_if #(
  parameter int N           = 12,
  parameter int COUNT_WIDTH = 16
);
  logic                   enable;
  logic                   frame_start;
  logic [COUNT_WIDTH-1:0] size;
  logic [N-1:0]           data_in;
  logic [N-1:0]           taps0;
  logic [N-1:0]           red;
  logic [N-1:0]           green;
  logic [N-1:0]           blue;
  logic                   out_valid;
  logic [COUNT_WIDTH-1:0] x_out;
  logic [COUNT_WIDTH-1:0] y_out;

  modport master (
    output enable, frame_start, size, data_in, taps0,
    input  red, green, blue, out_valid, x_out, y_out
  );

  modport slave (
    input  enable, frame_start, size, data_in, taps0,
    output red, green, blue, out_valid, x_out, y_out
  );
endinterface

// File: rtl/bayer_rgb_reader_pixel_counter.sv
// Column/row position tracker for the Bayer stream; flags the pixel that completes a 2x2 quad.
module bayer_pixel_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic [COUNT_WIDTH-1:0] size,
  output logic [COUNT_WIDTH-1:0] col,
  output logic [COUNT_WIDTH-1:0] row,
  output logic                   quad_done
);

  logic [COUNT_WIDTH-1:0] size_q;
  logic                   last_col;

  assign last_col  = (col == size_q - COUNT_WIDTH'(1));
  // size_q==0 means no frame has been seen since reset, so nothing is emitted
  assign quad_done = enable & ~frame_start & col[0] & row[0] & (size_q != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col    <= '0;
      row    <= '0;
      size_q <= '0;
    end else if (frame_start) begin
      col    <= '0;
      row    <= '0;
      size_q <= size;
    end else if (enable) begin
      if (last_col) begin
        col <= '0;
        if (row != '1) row <= row + COUNT_WIDTH'(1);
      end else begin
        col <= col + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/bayer_rgb_reader.sv
// Assembles 2x2 Bayer quads from live pixel + one-line-delayed tap and emits one RGB pixel per quad.
module bayer_rgb_reader
  import bayer_pkg::*;
#(
  parameter int N             = PIX_W_DEF,
  parameter int COUNT_WIDTH   = CNT_W_DEF,
  parameter int BAYER_PATTERN = BAYER_GRBG
) (
  input logic               clock,
  input logic               reset_n,
  bayer_rgb_reader_if.slave bus
);

  logic [COUNT_WIDTH-1:0] col, row;
  logic                   quad_done;
  logic                   shift_en;
  logic [N-1:0]           d0, d1;
  logic [N-1:0]           p00, p01, p10, p11;
  logic [N-1:0]           r_sel, b_sel, ga, gb;
  logic [N:0]             green_sum;

  bayer_pixel_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_cnt (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (bus.enable),
    .frame_start (bus.frame_start),
    .size        (bus.size),
    .col         (col),
    .row         (row),
    .quad_done   (quad_done)
  );

  // frame_start wins over enable: the coincident pixel never enters the window
  assign shift_en = bus.enable & ~bus.frame_start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d0 <= '0;
      d1 <= '0;
    end else if (shift_en) begin
      d0 <= bus.data_in;
      d1 <= bus.taps0;
    end
  end

  // On the odd column the quad is the held even-column pair plus the live pair
  assign p00 = d1;
  assign p01 = bus.taps0;
  assign p10 = d0;
  assign p11 = bus.data_in;

  always_comb begin
    r_sel = p01;
    b_sel = p10;
    ga    = p00;
    gb    = p11;
    case (BAYER_PATTERN)
      BAYER_RGGB: begin r_sel = p00; b_sel = p11; ga = p01; gb = p10; end
      BAYER_BGGR: begin r_sel = p11; b_sel = p00; ga = p01; gb = p10; end
      BAYER_GBRG: begin r_sel = p10; b_sel = p01; ga = p00; gb = p11; end
      default:    begin r_sel = p01; b_sel = p10; ga = p00; gb = p11; end
    endcase
  end

  assign green_sum = {1'b0, ga} + {1'b0, gb};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.red       <= '0;
      bus.green     <= '0;
      bus.blue      <= '0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
    end else begin
      bus.out_valid <= quad_done;
      if (quad_done) begin
        bus.red   <= r_sel;
        bus.green <= green_sum[N:1];
        bus.blue  <= b_sel;
        bus.x_out <= {1'b0, col[COUNT_WIDTH-1:1]};
        bus.y_out <= {1'b0, row[COUNT_WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_bayer_rgb_reader.sv
// Directed bench for bayer_rgb_reader (GRBG, 12-bit pixels, 16-bit counters).
module tb_bayer_rgb_reader;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  always #5 clock = ~clock;

  bayer_rgb_reader_if #(.N(12), .COUNT_WIDTH(16)) bus ();

  bayer_rgb_reader #(.N(12), .COUNT_WIDTH(16), .BAYER_PATTERN(0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [11:0] val(input int base, input int r, input int c);
    return 12'((base + r * 257 + c * 1031) % 4096);
  endfunction

  task automatic feed(input logic [11:0] d, input logic [11:0] t);
    bus.enable  = 1'b1;
    bus.data_in = d;
    bus.taps0   = t;
    step();
    bus.enable  = 1'b0;
  endtask

  task automatic sync(input int w, input bit en, input logic [11:0] d);
    bus.frame_start = 1'b1;
    bus.size        = 16'(w);
    bus.enable      = en;
    bus.data_in     = d;
    bus.taps0       = d;
    step();
    chk("fs_valid", bus.out_valid, 0);
    bus.frame_start = 1'b0;
    bus.enable      = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_red"},   bus.red,   0);
    chk({tag, "_green"}, bus.green, 0);
    chk({tag, "_blue"},  bus.blue,  0);
    chk({tag, "_x"},     bus.x_out, 0);
    chk({tag, "_y"},     bus.y_out, 0);
  endtask

  // GRBG quad at (r-1..r, c-1..c): G R / B G
  task automatic run_rows(input int w, input int h, input int base, input bit toggle, output int np);
    bit exp_v;
    int g;
    np = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        feed(val(base, r, c), (r > 0) ? val(base, r - 1, c) : 12'hA5A);
        exp_v = (c % 2 == 1) && (r % 2 == 1);
        chk("valid", bus.out_valid, exp_v);
        if (exp_v) begin
          np++;
          g = (int'(val(base, r - 1, c - 1)) + int'(val(base, r, c))) / 2;
          chk("red",   bus.red,   val(base, r - 1, c));
          chk("blue",  bus.blue,  val(base, r, c - 1));
          chk("green", bus.green, g);
          chk("x_out", bus.x_out, c / 2);
          chk("y_out", bus.y_out, r / 2);
        end
        if (toggle) begin
          step();
          chk("gap_valid", bus.out_valid, 0);
        end
      end
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.frame_start = 1'b0;
    bus.size        = '0;
    bus.data_in     = '0;
    bus.taps0       = '0;
    #2;
    outs_zero("rst");
    step();
    step();
    reset_n = 1'b1;

    // no frame_start yet: nothing may come out
    for (int i = 0; i < 8; i++) begin
      feed(12'(i * 100 + 1), 12'(i * 50 + 3));
      chk("noframe_valid", bus.out_valid, 0);
    end

    // hand-computed GRBG quads, size 4
    sync(4, 1'b0, 12'd0);
    feed(12'd100, 12'd0); feed(12'd200, 12'd0); feed(12'd100, 12'd0); feed(12'd200, 12'd0);
    feed(12'd50, 12'd100);
    chk("l1c0_valid", bus.out_valid, 0);
    feed(12'd120, 12'd200);
    chk("q0_valid", bus.out_valid, 1);
    chk("q0_red",   bus.red,   200);
    chk("q0_green", bus.green, 110);
    chk("q0_blue",  bus.blue,  50);
    chk("q0_x",     bus.x_out, 0);
    chk("q0_y",     bus.y_out, 0);
    feed(12'd50, 12'd100);
    chk("l1c2_valid", bus.out_valid, 0);
    chk("hold_red",   bus.red, 200);
    feed(12'd120, 12'd200);
    chk("q1_valid", bus.out_valid, 1);
    chk("q1_x",     bus.x_out, 1);
    chk("q1_y",     bus.y_out, 0);

    // async reset away from the clock edge clears outputs immediately
    #2;
    reset_n = 1'b0;
    #1;
    outs_zero("midrst");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      feed(12'(i + 7), 12'(i + 9));
      chk("postrst_valid", bus.out_valid, 0);
    end
    sync(4, 1'b0, 12'd0);
    run_rows(4, 2, 11, 1'b0, pulses);
    chk("postrst_pulses", pulses, 2);

    // toggled enable, size 6
    sync(6, 1'b0, 12'd0);
    run_rows(6, 4, 77, 1'b1, pulses);
    chk("s6_pulses", pulses, 6);

    // odd width: last column unpaired
    sync(5, 1'b0, 12'd0);
    run_rows(5, 4, 300, 1'b0, pulses);
    chk("s5_pulses", pulses, 4);

    // width 1: never a quad
    sync(1, 1'b0, 12'd0);
    run_rows(1, 4, 5, 1'b0, pulses);
    chk("s1_pulses", pulses, 0);

    // frame_start with enable mid-line drops that pixel
    sync(4, 1'b0, 12'd0);
    run_rows(4, 1, 40, 1'b0, pulses);
    feed(12'd321, 12'd123);
    sync(4, 1'b1, 12'd999);
    run_rows(4, 2, 900, 1'b0, pulses);
    chk("fsen_pulses", pulses, 2);

    // green truncation near full scale
    sync(2, 1'b0, 12'd0);
    feed(12'd4095, 12'd0); feed(12'd7, 12'd0);
    feed(12'd9, 12'd4095);
    feed(12'd4094, 12'd7);
    chk("gmax_valid", bus.out_valid, 1);
    chk("gmax_green", bus.green, 4094);
    chk("gmax_red",   bus.red,   7);
    chk("gmax_blue",  bus.blue,  9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
